instr_prefetch_ir: RTL and testbench
====================================

Name: instr_prefetch_ir

Overview:
Parametrised successor to the single-entry instruction register of the 16-bit multicycle core. It adds a DEPTH-entry prefetch FIFO between instruction memory and the IR, so memory can push instructions ahead of the control FSM. It also adds a flush for taken branches/jumps. On a pop, the head entry is loaded into the IR, and the decoded fields are driven from the IR.

Parameters:
IW, 16, instruction width in bits; must be >= 16.
DEPTH, 4, FIFO entries; power of 2, >= 2.
CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
D_MemData  in  IW  instruction word from memory.
wr_valid  in  1  memory presents D_MemData.
wr_ready  out  1  FIFO can accept a word.
C_Flush  in  1  discard all queued words (taken branch/jmp).
C_IRWrite  in  1  control FSM requests the next instruction into the IR.
rd_valid  out  1  FIFO head holds a valid word.
OPCODE  out  4  IR[IW-1:IW-4].
A_ReadReg1RT  out  4  IR[IW-5:IW-8].
A_ReadReg2RT  out  4  IR[IW-9:IW-12].
FUNCFIELD  out  4  IR[3:0].
A_Imm  out  IW-8  IR[IW-9:0] (imm8/offset field at IW=16).
A_Jmp  out  IW-4  IR[IW-5:0] (jump target).
ir_loaded  out  1  pulses high 1 cycle after each IR load.
count  out  CW  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge) clears the IR, the pointers and count.
  - Afterwards: IR=0, all field outputs 0, count=0, rd_valid=0, wr_ready=1, ir_loaded=0.
  - rst has priority over every other input.
- Storage and status:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
  - wr_ready = (count != DEPTH); rd_valid = (count != 0). Both are purely registered-state functions, with no combinational path from inputs.
- Push when wr_valid && wr_ready: mem[wr_ptr] <= D_MemData; wr_ptr++.
- Pop when C_IRWrite && rd_valid: IR <= mem[rd_ptr]; rd_ptr++; ir_loaded <= 1 on that edge, otherwise 0.
- Count update: push only -> count+1; pop only -> count-1; push and pop in the same cycle -> count unchanged, both pointers advance.
- Full: wr_ready=0, so a push is impossible. A pop in the same cycle does not enable a same-cycle push; wr_ready rises the next cycle.
- Empty: rd_valid=0, so C_IRWrite is ignored and the IR holds its value. A push in this cycle makes rd_valid=1 after the edge.
- Latency (base build): word pushed at edge N; earliest IR load at edge N+1; fields valid after edge N+1.
- Flush (C_Flush=1, rst=0):
  - Next edge sets count=0, wr_ptr=rd_ptr=0.
  - A push in the same cycle is discarded.
  - A pop in the same cycle still loads the IR: the IR instruction is already committed.
  - The IR itself is never cleared by flush.
- The IR holds its value whenever no pop occurs; the field outputs follow the IR combinationally.
- Memory array contents are not reset. Stale entries are never visible because every read is gated by count.

Optional Feature:
IQ_BYPASS_EN:
- Defined: when count==0 && wr_valid && C_IRWrite && !C_Flush, D_MemData loads straight into the IR at that edge.
  - FIFO is untouched; count stays 0; ir_loaded pulses.
  - Gives zero-latency fetch on an empty queue.
  - wr_ready stays 1 while empty, so the word is accepted.
- Undefined: no bypass; C_IRWrite on an empty FIFO is ignored; latency as in Behaviour.

Test Plan:
- Reset with rst=1 for 2 cycles, C_IRWrite=1 -> OPCODE=0, count=0, rd_valid=0, wr_ready=1, ir_loaded=0.
- Push 16'h8B48 (add), C_IRWrite=1 next cycle -> after the load edge: OPCODE=8, A_ReadReg1RT=B, A_ReadReg2RT=4, FUNCFIELD=8, ir_loaded=1 for one cycle.
- Push 16'h8B48, 16'h9BC9, 16'h0B41, 16'h2BC9 with no pops -> count=4, wr_ready=0; a 5th push (16'h3B78) is dropped. Four pops yield OPCODE 8, 9, 0, 2 in order; A_Imm=8'hC9 on the 2nd and 4th.
- Six push+pop cycles back-to-back at count=2 -> count stays 2, pointers wrap, FIFO order is preserved.
- With count=3, C_Flush=1 plus push 16'h3B78 plus C_IRWrite=1 -> IR loads the head word; count=0 afterwards; 16'h3B78 never appears.
- IQ_BYPASS_EN builds: empty FIFO, push 16'h2BC9 with C_IRWrite=1 in the same cycle -> OPCODE=2, A_Imm=8'hC9 after that edge, count=0. Non-bypass builds: OPCODE unchanged and count=1 after that edge.

Source files
------------

// File: rtl/instr_prefetch_ir.sv
// ---------------------------------------------------------------------------
// instr_prefetch_ir
//
// Instruction register fronted by a DEPTH-entry prefetch FIFO. Instruction
// memory pushes words ahead of the control FSM; the FSM pops the head into
// the IR with C_IRWrite, and the decoded fields are driven from the IR.
// C_Flush empties the queue on a taken branch/jump without touching the IR.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (priority over all inputs)
//   D_MemData     instruction word from memory
//   wr_valid      memory presents D_MemData
//   wr_ready      FIFO can accept a word (registered-state function)
//   C_Flush       discard all queued words
//   C_IRWrite     load the next instruction into the IR
//   rd_valid      FIFO head holds a valid word (registered-state function)
//   OPCODE        IR[IW-1:IW-4]
//   A_ReadReg1RT  IR[IW-5:IW-8]
//   A_ReadReg2RT  IR[IW-9:IW-12]
//   FUNCFIELD     IR[3:0]
//   A_Imm         IR[IW-9:0]
//   A_Jmp         IR[IW-5:0]
//   ir_loaded     high for one cycle after each IR load
//   count         current FIFO occupancy
//
// Optional feature macro: IQ_BYPASS_EN
//   When defined, a word arriving while the queue is empty and C_IRWrite is
//   asserted (and no flush) goes straight into the IR at that edge; the FIFO
//   is left untouched. When undefined, C_IRWrite on an empty queue is ignored.
// ---------------------------------------------------------------------------
module instr_prefetch_ir #(
  parameter int IW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] D_MemData,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic          C_Flush,
  input  logic          C_IRWrite,
  output logic          rd_valid,
  output logic [3:0]    OPCODE,
  output logic [3:0]    A_ReadReg1RT,
  output logic [3:0]    A_ReadReg2RT,
  output logic [3:0]    FUNCFIELD,
  output logic [IW-9:0] A_Imm,
  output logic [IW-5:0] A_Jmp,
  output logic          ir_loaded,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [IW-1:0] ir;

  logic push;
  logic pop;
  logic bypass;

  // Status flags depend only on the registered count, so there is no
  // combinational path from wr_valid/C_IRWrite back to wr_ready/rd_valid.
  assign wr_ready = (count != CW'(DEPTH));
  assign rd_valid = (count != '0);

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pop    = 1'b0;
    bypass = 1'b0;
    push   = 1'b0;

    pop = C_IRWrite && rd_valid;
`ifdef IQ_BYPASS_EN
    // Empty queue and the FSM wants an instruction now: hand the incoming
    // word directly to the IR instead of queueing it.
    bypass = (count == '0) && wr_valid && C_IRWrite && !C_Flush;
`else
    bypass = 1'b0;
`endif
    // A flush discards any word offered in the same cycle; a bypassed word
    // never enters the queue.
    push = wr_valid && wr_ready && !C_Flush && !bypass;
  end

  // NOTE: the storage array has no reset. Reading is always gated by count,
  // so stale entries are never observable, and leaving it unreset lets it map
  // onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= D_MemData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ir        <= '0;
      ir_loaded <= 1'b0;
    end else begin
      ir_loaded <= pop || bypass;

      // A pop coinciding with a flush still commits the head word: that
      // instruction was already selected before the branch resolved.
      if (pop) begin
        ir <= mem[rd_ptr];
      end else if (bypass) begin
        ir <= D_MemData;
      end

      if (C_Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        // DEPTH is a power of two, so pointer wrap is the natural overflow.
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Decoded fields follow the IR combinationally.
  assign OPCODE       = ir[IW-1:IW-4];
  assign A_ReadReg1RT = ir[IW-5:IW-8];
  assign A_ReadReg2RT = ir[IW-9:IW-12];
  assign FUNCFIELD    = ir[3:0];
  assign A_Imm        = ir[IW-9:0];
  assign A_Jmp        = ir[IW-5:0];

endmodule

// File: tb/tb_instr_prefetch_ir.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch_ir
//
// Self-checking bench for instr_prefetch_ir. A queue-based reference model
// tracks the queued words, the IR and the load pulse; a negedge compare
// process checks every output against it each cycle once reset has been seen.
// A directed sequence adds literal expectations, then randomized traffic
// (pushes, pops, flushes, occasional resets) runs against the model.
// ---------------------------------------------------------------------------
module tb_instr_prefetch_ir;

  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] D_MemData;
  logic          wr_valid;
  logic          wr_ready;
  logic          C_Flush;
  logic          C_IRWrite;
  logic          rd_valid;
  logic [3:0]    OPCODE;
  logic [3:0]    A_ReadReg1RT;
  logic [3:0]    A_ReadReg2RT;
  logic [3:0]    FUNCFIELD;
  logic [IW-9:0] A_Imm;
  logic [IW-5:0] A_Jmp;
  logic          ir_loaded;
  logic [CW-1:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_prefetch_ir #(.IW(IW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .D_MemData    (D_MemData),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .C_Flush      (C_Flush),
    .C_IRWrite    (C_IRWrite),
    .rd_valid     (rd_valid),
    .OPCODE       (OPCODE),
    .A_ReadReg1RT (A_ReadReg1RT),
    .A_ReadReg2RT (A_ReadReg2RT),
    .FUNCFIELD    (FUNCFIELD),
    .A_Imm        (A_Imm),
    .A_Jmp        (A_Jmp),
    .ir_loaded    (ir_loaded),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [IW-1:0] mq[$];
  logic [IW-1:0] ir_m;
  logic          loaded_m;
  bit            model_ok = 0;

  always @(posedge clk) begin
    int  n;
    bit  do_pop;
    bit  byp;
    bit  can_push;
    if (rst) begin
      mq.delete();
      ir_m     = '0;
      loaded_m = 1'b0;
      model_ok = 1;
    end else if (model_ok) begin
      n        = mq.size();
      can_push = (n < DEPTH);
      do_pop   = C_IRWrite && (n > 0);
`ifdef IQ_BYPASS_EN
      byp = (n == 0) && wr_valid && C_IRWrite && !C_Flush;
`else
      byp = 0;
`endif
      loaded_m = do_pop || byp;
      if (do_pop) ir_m = mq[0];
      else if (byp) ir_m = D_MemData;
      if (C_Flush) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (wr_valid && can_push && !byp) mq.push_back(D_MemData);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      check("count",     32'(count),        32'(mq.size()));
      check("rd_valid",  32'(rd_valid),     32'(mq.size() != 0));
      check("wr_ready",  32'(wr_ready),     32'(mq.size() != DEPTH));
      check("ir_loaded", 32'(ir_loaded),    32'(loaded_m));
      check("OPCODE",    32'(OPCODE),       32'(ir_m[15:12]));
      check("RR1",       32'(A_ReadReg1RT), 32'(ir_m[11:8]));
      check("RR2",       32'(A_ReadReg2RT), 32'(ir_m[7:4]));
      check("FUNC",      32'(FUNCFIELD),    32'(ir_m[3:0]));
      check("A_Imm",     32'(A_Imm),        32'(ir_m[7:0]));
      check("A_Jmp",     32'(A_Jmp),        32'(ir_m[11:0]));
    end
  end

  // Apply one cycle of inputs, then land just after the edge that used them.
  task automatic step(input logic r, input logic wv, input logic [IW-1:0] d,
                      input logic fl, input logic irw);
    rst       = r;
    wr_valid  = wv;
    D_MemData = d;
    C_Flush   = fl;
    C_IRWrite = irw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [IW-1:0] words [4];
    words[0] = 16'h8B48;
    words[1] = 16'h9BC9;
    words[2] = 16'h0B41;
    words[3] = 16'h2BC9;

    rst = 1'b1; wr_valid = 1'b0; D_MemData = '0; C_Flush = 1'b0; C_IRWrite = 1'b0;

    // Reset, 2 cycles, with C_IRWrite held high.
    step(1, 0, 16'h0, 0, 1);
    step(1, 0, 16'h0, 0, 1);
    check("rst OPCODE",    32'(OPCODE),    32'h0);
    check("rst count",     32'(count),     32'h0);
    check("rst rd_valid",  32'(rd_valid),  32'h0);
    check("rst wr_ready",  32'(wr_ready),  32'h1);
    check("rst ir_loaded", 32'(ir_loaded), 32'h0);

    // Single push, pop next cycle.
    step(0, 1, 16'h8B48, 0, 0);
    check("push1 count", 32'(count), 32'h1);
    step(0, 0, 16'h0, 0, 1);
    check("add OPCODE",    32'(OPCODE),       32'h8);
    check("add RR1",       32'(A_ReadReg1RT), 32'hB);
    check("add RR2",       32'(A_ReadReg2RT), 32'h4);
    check("add FUNC",      32'(FUNCFIELD),    32'h8);
    check("add ir_loaded", 32'(ir_loaded),    32'h1);
    step(0, 0, 16'h0, 0, 0);
    check("add ir_loaded drop", 32'(ir_loaded), 32'h0);

    // Fill to full, then a dropped 5th push.
    for (int i = 0; i < 4; i++) step(0, 1, words[i], 0, 0);
    check("full count",    32'(count),    32'h4);
    check("full wr_ready", 32'(wr_ready), 32'h0);
    step(0, 1, 16'h3B78, 0, 0);
    check("drop count", 32'(count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_op [4];
      exp_op[0] = 4'h8; exp_op[1] = 4'h9; exp_op[2] = 4'h0; exp_op[3] = 4'h2;
      step(0, 0, 16'h0, 0, 1);
      check("drain OPCODE", 32'(OPCODE), 32'(exp_op[i]));
      if (i == 1 || i == 3) check("drain A_Imm", 32'(A_Imm), 32'hC9);
    end
    check("drained count", 32'(count), 32'h0);
    // Pop on empty: ignored, IR holds.
    step(0, 0, 16'h0, 0, 1);
    check("empty pop OPCODE", 32'(OPCODE),    32'h2);
    check("empty pop loaded", 32'(ir_loaded), 32'h0);

    // Back-to-back push+pop at count=2 with pointer wrap.
    step(0, 1, 16'h1111, 0, 0);
    step(0, 1, 16'h2222, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, {4'(i + 3), 12'hABC}, 0, 1);
      check("stream count", 32'(count), 32'h2);
    end
    // Popped: 1111, 2222, then words with opcode 3,4,5,6.
    check("stream OPCODE", 32'(OPCODE), 32'h6);

    // count=3, then flush + push + pop in one cycle.
    step(0, 1, 16'h7123, 0, 0);
    check("pre-flush count", 32'(count), 32'h3);
    step(0, 1, 16'h3B78, 1, 1);
    check("flush OPCODE", 32'(OPCODE),    32'h7);
    check("flush A_Jmp",  32'(A_Jmp),     32'hABC);
    check("flush count",  32'(count),     32'h0);
    check("flush loaded", 32'(ir_loaded), 32'h1);
    step(0, 0, 16'h0, 0, 1);
    check("post-flush OPCODE", 32'(OPCODE),   32'h7);
    check("post-flush rd_valid", 32'(rd_valid), 32'h0);

    // Push with C_IRWrite on an empty queue.
    step(0, 1, 16'h2BC9, 0, 1);
`ifdef IQ_BYPASS_EN
    check("bypass OPCODE", 32'(OPCODE), 32'h2);
    check("bypass A_Imm",  32'(A_Imm),  32'hC9);
    check("bypass count",  32'(count),  32'h0);
`else
    check("nobypass OPCODE", 32'(OPCODE), 32'h7);
    check("nobypass count",  32'(count),  32'h1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) != 0),
           IW'($urandom),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
